// File: rtl/gf180mcu_fd_sc_mcu7t5v0__piso_tx.sv
// Parallel-in / serial-out frame transmitter.
// A word is captured on a valid/ready handshake. It is then presented on SO
// one bit per enabled cycle, with FRAME marking the first bit. SHIFT_EN stalls
// the frame in place. A new word can be taken on the last bit, so frames can
// run back to back with no idle gap.
//
// Handshake: a transfer happens on the rising CLK edge where LOAD_VALID=1 and
// LOAD_READY=1. LOAD_READY is a function of state, bit count, SHIFT_EN and RST
// only, and never of LOAD_VALID. It is high in IDLE, and high in SHIFT only
// while the last bit is on SO and SHIFT_EN=1.
module gf180mcu_fd_sc_mcu7t5v0__piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic             SHIFT_EN,
  output logic             SO,
  output logic             SO_VALID,
  output logic             FRAME,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             so_q, so_d;
  logic             so_valid_q, so_valid_d;
  logic             frame_q, frame_d;

  logic             busy, last_bit, transfer, step, stall, keep;
  logic             first_bit, next_bit;
  logic [WIDTH-1:0] load_rest, shift_rest;

  // Next-state selection. Ternaries are used on purpose: an unknown
  // LOAD_VALID or SHIFT_EN then spreads X into the state in simulation
  // instead of silently falling into an else branch.
  always_comb begin
    busy       = (state_q == ST_SHIFT);
    last_bit   = (cnt_q == CW'(WIDTH));
    LOAD_READY = ~RST & (~busy | (last_bit & SHIFT_EN));
    transfer   = LOAD_VALID & LOAD_READY;
    step       = busy & SHIFT_EN & ~last_bit;
    stall      = busy & ~SHIFT_EN;
    keep       = transfer | step | stall;

    // The first bit goes straight to SO, and the remaining bits are parked
    // in the shift register so the outgoing bit is always at the same end.
    first_bit  = MSB_FIRST ? D[WIDTH-1] : D[0];
    load_rest  = MSB_FIRST ? (D << 1) : (D >> 1);
    next_bit   = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    shift_rest = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);

    state_d    = keep ? ST_SHIFT : ST_IDLE;
    sreg_d     = transfer ? load_rest  : (step ? shift_rest      : (stall ? sreg_q  : '0));
    so_d       = transfer ? first_bit  : (step ? next_bit        : (stall ? so_q    : 1'b0));
    frame_d    = transfer ? 1'b1       : (step ? 1'b0            : (stall ? frame_q : 1'b0));
    cnt_d      = transfer ? CW'(1)     : (step ? cnt_q + CW'(1)  : (stall ? cnt_q   : '0));
    so_valid_d = keep;
  end

  // State and registered outputs. Reset clears everything without a clock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      sreg_q     <= '0;
      cnt_q      <= '0;
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      so_q       <= so_d;
      so_valid_q <= so_valid_d;
      frame_q    <= frame_d;
    end
  end

  assign SO       = so_q;
  assign SO_VALID = so_valid_q;
  assign FRAME    = frame_q;
  assign BUSY     = busy;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__piso_tx.sv
// Bench for the PISO transmitter: three instances
// (8-bit MSB-first, 8-bit LSB-first, 32-bit MSB-first).
// Each accepted word is expanded into its expected bit stream, and a
// falling-edge monitor consumes that stream as the DUT presents bits.
module tb_gf180mcu_fd_sc_mcu7t5v0__piso_tx;

  logic        clk;
  logic        rst;
  logic [31:0] d_in [3];
  logic [2:0]  lv;
  logic [2:0]  se;
  wire  [2:0]  lr, so, sov, fr, bz;

  int checks   = 0;
  int failures = 0;
  bit done     = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- DUTs, scoreboards, monitors ----------------
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 2) ? 32 : 8;
    localparam bit M = (g == 1) ? 1'b0 : 1'b1;

    // Each entry is {first_bit_of_frame, bit_value}, in transmit order.
    logic [1:0] exp_q [$];

    gf180mcu_fd_sc_mcu7t5v0__piso_tx #(.WIDTH(W), .MSB_FIRST(M)) u_dut (
      .CLK        (clk),
      .RST        (rst),
      .D          (d_in[g][W-1:0]),
      .LOAD_VALID (lv[g]),
      .LOAD_READY (lr[g]),
      .SHIFT_EN   (se[g]),
      .SO         (so[g]),
      .SO_VALID   (sov[g]),
      .FRAME      (fr[g]),
      .BUSY       (bz[g])
    );

    // A reset throws away any frame in progress.
    always @(posedge rst) exp_q.delete();

    // Expected stream: when a handshake is about to complete, append the word's bits.
    always @(negedge clk) begin
      int b;
      #2;
      if (!rst && lv[g] && lr[g]) begin
        for (int i = 0; i < W; i++) begin
          b = M ? (W - 1 - i) : i;
          exp_q.push_back({(i == 0), d_in[g][b]});
        end
      end
    end

    // Falling-edge capture: compare what is on SO, and consume the bit if it advances.
    always @(negedge clk) begin
      int exp_rdy;
      logic [1:0] f;
      if (rst) begin
        chk($sformatf("d%0d_reset_outputs", g), {lr[g], so[g], sov[g], fr[g], bz[g]}, 0);
      end else begin
        exp_rdy = (exp_q.size() == 0 || (exp_q.size() == 1 && se[g])) ? 1 : 0;
        chk($sformatf("d%0d_load_ready", g), lr[g], exp_rdy);
        if (sov[g]) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("d%0d_unexpected_valid", g), sov[g], 0);
          end else begin
            f = exp_q[0];
            chk($sformatf("d%0d_so", g), so[g], f[0]);
            chk($sformatf("d%0d_frame", g), fr[g], f[1]);
            chk($sformatf("d%0d_busy", g), bz[g], 1);
            if (se[g]) void'(exp_q.pop_front());
          end
        end else begin
          chk($sformatf("d%0d_idle_outputs", g), {so[g], fr[g], bz[g]}, 0);
          chk($sformatf("d%0d_missing_bits", g), exp_q.size(), 0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Call at posedge+1. Present w until accepted; return at posedge+1 after the accepting edge.
  task automatic send(input int i, input logic [31:0] w, input bit rnd_se);
    int  n;
    bit  got;
    n   = 0;
    got = 0;
    d_in[i] = w;
    lv[i]   = 1'b1;
    while (!got) begin
      if (rnd_se) se[i] = ($urandom_range(0, 3) != 0);
      #1;
      if (lr[i]) begin
        got = 1;
      end else if (n >= 400) begin
        chk($sformatf("d%0d_load_timeout", i), lr[i], 1);
        got = 1;
      end else begin
        n++;
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic report();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_valid;
    logic [31:0] w;
    rst = 1'b1;
    lv  = '0;
    se  = 3'b111;
    for (int i = 0; i < 3; i++) d_in[i] = '0;

    #1;
    chk("reset_load_ready", lr, 0);
    chk("reset_outputs", {so, sov, fr, bz}, 0);

    // 0xA5 offered during reset, accepted on the first edge after release.
    d_in[0] = 32'hA5;
    lv[0]   = 1'b1;
    #20 rst = 1'b0;
    @(posedge clk); #1;
    lv[0] = 1'b0;
    chk("first_edge_transfer", {so[0], sov[0], fr[0], bz[0]}, 4'b1111);
    cycles(10);

    // Back-to-back frames with LOAD_VALID held.
    send(0, 32'hA5, 0);
    send(0, 32'h3C, 0);
    lv[0] = 1'b0;
    cycles(20);

    // LSB-first 0x01 with a three-cycle stall on the first bit.
    send(1, 32'h01, 0);
    lv[1]   = 1'b0;
    se[1]   = 1'b0;
    n_valid = 0;
    for (int c = 0; c < 20; c++) begin
      if (sov[1] === 1'b1) n_valid++;
      @(posedge clk); #1;
      if (c == 2) se[1] = 1'b1;
    end
    chk("stall_valid_cycles", n_valid, 11);

    // D changes right after acceptance; the frame keeps the captured word.
    send(0, 32'hFF, 0);
    d_in[0] = 32'h00;
    lv[0]   = 1'b0;
    cycles(12);

    // Asynchronous reset in the middle of a frame.
    send(0, 32'hFF, 0);
    lv[0] = 1'b0;
    cycles(3);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", {so[0], sov[0], fr[0], bz[0]}, 0);
    chk("async_reset_ready", lr[0], 0);
    #2 rst = 1'b0;
    #1;
    chk("ready_after_reset", lr[0], 1);
    cycles(12);

    // Random words, random stalls, random gaps, on all three widths and orders.
    for (int i = 0; i < 3; i++) begin
      repeat (25) begin
        w = $urandom;
        if (i != 2) w = w & 32'hFF;
        send(i, w, 1);
        if ($urandom_range(0, 1) == 1) begin
          lv[i] = 1'b0;
          repeat ($urandom_range(0, 3)) begin
            se[i] = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
          end
        end
      end
      lv[i] = 1'b0;
      se[i] = 1'b1;
      cycles(80);
    end

    chk("d0_leftover", g_dut[0].exp_q.size(), 0);
    chk("d1_leftover", g_dut[1].exp_q.size(), 0);
    chk("d2_leftover", g_dut[2].exp_q.size(), 0);
    done = 1;
    report();
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    if (!done) begin
      failures++;
      $display("FAIL watchdog actual=%0d expected=%0d", 0, 1);
      report();
      $finish;
    end
  end

endmodule
